// File: rtl/button_capture.sv
// button_capture: Simon Says player-input receiver.
// Synchronises, debounces and validates the four colour buttons and emits
// one 2-bit colour code per physical press as a single-cycle strobe.
// Build option: define BUTTON_SYNC_EN to insert the 2-flop input
// synchroniser (silicon build). Left undefined, the raw buttons feed the
// FSM directly and the strobe comes two cycles earlier (fast gate-level sim).
module button_capture #(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int CNT_W           = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic [3:0] btn,
    output logic       colour_valid,
    output logic [1:0] colour_val,
    output logic       multi_err,
    output logic       busy
);

    localparam logic [CNT_W-1:0] DB_CNT  = CNT_W'(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    typedef enum logic [1:0] {
        S_IDLE       = 2'd0,
        S_PRESS_DB   = 2'd1,
        S_HELD       = 2'd2,
        S_RELEASE_DB = 2'd3
    } state_t;

    state_t           state_q;
    logic [CNT_W-1:0] cnt_q;
    logic [3:0]       onehot_q;
    logic             colour_valid_q;
    logic [1:0]       colour_val_q;
    logic             multi_err_q;

    // Button sample the FSM works from
    logic [3:0]       bs;

`ifdef BUTTON_SYNC_EN
    logic [3:0] sync1_q;
    logic [3:0] sync2_q;

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_sync
            // Two-flop synchroniser per raw button line
            always_ff @(posedge clk) begin
                if (rst) begin
                    sync1_q[gi] <= 1'b0;
                    sync2_q[gi] <= 1'b0;
                end else begin
                    sync1_q[gi] <= btn[gi];
                    sync2_q[gi] <= sync1_q[gi];
                end
            end
        end
    endgenerate

    assign bs = sync2_q;
`else
    assign bs = btn;
`endif

    // Classification of the current sample and the saturating count step
    logic             bs_any;
    logic             bs_onehot;
    logic             bs_multi;
    logic [CNT_W-1:0] cnt_inc_d;

    assign bs_any    = |bs;
    assign bs_onehot = bs_any && ((bs & (bs - 4'd1)) == 4'd0);
    assign bs_multi  = bs_any && !bs_onehot;
    assign cnt_inc_d = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_ONE;

    // One-hot to colour code; only ever called with a one-hot argument
    function automatic logic [1:0] encode(input logic [3:0] oh);
        logic [1:0] code;
        case (oh)
            4'b0010: code = 2'd1;
            4'b0100: code = 2'd2;
            4'b1000: code = 2'd3;
            default: code = 2'd0;
        endcase
        return code;
    endfunction

    // Press/release debounce FSM with registered strobes
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= S_IDLE;
            cnt_q          <= '0;
            onehot_q       <= '0;
            colour_valid_q <= 1'b0;
            colour_val_q   <= 2'd0;
            multi_err_q    <= 1'b0;
        end else begin
            colour_valid_q <= 1'b0;
            multi_err_q    <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (en && bs_onehot) begin
                        onehot_q <= bs;
                        if (DEBOUNCE_CYCLES == 1) begin
                            // A single stable sample is already a full debounce
                            colour_valid_q <= 1'b1;
                            colour_val_q   <= encode(bs);
                            cnt_q          <= '0;
                            state_q        <= S_HELD;
                        end else begin
                            cnt_q   <= CNT_ONE;
                            state_q <= S_PRESS_DB;
                        end
                    end else if (en && bs_multi) begin
                        // Ambiguous press: flag it, then wait for a clean release
                        multi_err_q <= 1'b1;
                        cnt_q       <= '0;
                        state_q     <= S_RELEASE_DB;
                    end
                end
                S_PRESS_DB: begin
                    if (!en) begin
                        // Capture window closed mid-press: drop it, require release
                        cnt_q   <= '0;
                        state_q <= S_RELEASE_DB;
                    end else if (bs != onehot_q) begin
                        // Bounce, release or extra button before acceptance
                        cnt_q   <= '0;
                        state_q <= S_IDLE;
                    end else begin
                        cnt_q <= cnt_inc_d;
                        if (cnt_inc_d >= DB_CNT) begin
                            colour_valid_q <= 1'b1;
                            colour_val_q   <= encode(onehot_q);
                            cnt_q          <= '0;
                            state_q        <= S_HELD;
                        end
                    end
                end
                S_HELD: begin
                    // Extra buttons while held are deliberately ignored
                    if (!en) begin
                        cnt_q   <= '0;
                        state_q <= S_RELEASE_DB;
                    end else if (!bs_any) begin
                        if (DEBOUNCE_CYCLES == 1) begin
                            cnt_q   <= '0;
                            state_q <= S_IDLE;
                        end else begin
                            cnt_q   <= CNT_ONE;
                            state_q <= S_RELEASE_DB;
                        end
                    end
                end
                S_RELEASE_DB: begin
                    // Any activity restarts the clean-release count
                    if (bs_any) begin
                        cnt_q <= '0;
                    end else if (cnt_inc_d >= DB_CNT) begin
                        cnt_q   <= '0;
                        state_q <= S_IDLE;
                    end else begin
                        cnt_q <= cnt_inc_d;
                    end
                end
                default: begin
                    cnt_q   <= '0;
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign colour_valid = colour_valid_q;
    assign colour_val   = colour_val_q;
    assign multi_err    = multi_err_q;
    assign busy         = (state_q != S_IDLE);

endmodule

// File: tb/tb_button_capture.sv
// Self-checking bench for button_capture (DEBOUNCE_CYCLES=4).
// Expected strobes are queued when stimulus is applied and matched against
// the DUT strobes as they appear, including the exact cycle they occur in.
module tb_button_capture;

    localparam int DB = 4;
`ifdef BUTTON_SYNC_EN
    localparam int SYNC = 2;
`else
    localparam int SYNC = 0;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       en  = 1'b0;
    logic [3:0] btn = 4'b1111;
    logic       colour_valid;
    logic [1:0] colour_val;
    logic       multi_err;
    logic       busy;

    button_capture #(
        .DEBOUNCE_CYCLES(DB),
        .CNT_W          (4)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .en          (en),
        .btn         (btn),
        .colour_valid(colour_valid),
        .colour_val  (colour_val),
        .multi_err   (multi_err),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        int         cyc;
        bit         is_err;
        logic [1:0] val;
    } exp_t;

    exp_t       sb[$];
    int         n_cmp   = 0;
    int         n_err   = 0;
    int         cyc     = 0;
    bit         mon_en  = 1'b0;
    logic [1:0] prev_val = 2'd0;

    // Edge counter plus strobe monitor sampling 1 time unit after each edge
    always @(posedge clk) begin
        exp_t e;
        cyc = cyc + 1;
        #1;
        if (mon_en) begin
            if (colour_valid || multi_err) begin
                if (sb.size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL strobe_unexpected: cycle %0d valid=%b err=%b val=%0d, required no strobe",
                             cyc, colour_valid, multi_err, colour_val);
                end else begin
                    e = sb.pop_front();
                    n_cmp++;
                    if (cyc !== e.cyc || {colour_valid, multi_err} !== {!e.is_err, e.is_err} ||
                        (!e.is_err && colour_val !== e.val)) begin
                        n_err++;
                        $display("FAIL strobe_match: got cycle %0d valid=%b err=%b val=%0d, required cycle %0d valid=%b err=%b val=%0d",
                                 cyc, colour_valid, multi_err, colour_val,
                                 e.cyc, !e.is_err, e.is_err, e.val);
                    end else begin
                        $display("cycle %0d: %s strobe, colour_val=%0d", cyc,
                                 e.is_err ? "multi_err" : "colour_valid", colour_val);
                    end
                end
            end
            if (!rst && !colour_valid && colour_val !== prev_val) begin
                n_cmp++;
                n_err++;
                $display("FAIL colour_val_hold: cycle %0d changed to %0d without strobe, required %0d",
                         cyc, colour_val, prev_val);
            end
        end
        prev_val = colour_val;
    end

    task automatic step(input logic [3:0] b, input logic e, input int n);
        btn = b;
        en  = e;
        repeat (n) @(negedge clk);
    endtask

    // Raw btn applied now is first sampled by edge cyc+1
    task automatic expect_press(input logic [1:0] v);
        exp_t x;
        x.cyc    = cyc + 1 + SYNC + DB - 1;
        x.is_err = 1'b0;
        x.val    = v;
        sb.push_back(x);
    endtask

    task automatic expect_multi();
        exp_t x;
        x.cyc    = cyc + 1 + SYNC;
        x.is_err = 1'b1;
        x.val    = 2'd0;
        sb.push_back(x);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        en  = 1'b1;
        btn = 4'b1111;
        repeat (2) @(negedge clk);
        mon_en = 1'b1;
        n_cmp++; if (colour_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid: got %b, required 0", colour_valid); end
        n_cmp++; if (multi_err !== 1'b0) begin n_err++; $display("FAIL reset_multi_err: got %b, required 0", multi_err); end
        n_cmp++; if (colour_val !== 2'd0) begin n_err++; $display("FAIL reset_colour_val: got %0d, required 0", colour_val); end
        n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b, required 0", busy); end
        rst = 1'b0;
        step(4'b0000, 1'b1, 3);
        n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_after_busy: got %b, required 0", busy); end
    endtask

    task automatic test_clean_press();
        expect_press(2'd2);
        step(4'b0100, 1'b1, 30);
        n_cmp++; if (colour_val !== 2'd2) begin n_err++; $display("FAIL clean_val_held: got %0d, required 2", colour_val); end
        n_cmp++; if (busy !== 1'b1) begin n_err++; $display("FAIL clean_busy_held: got %b, required 1", busy); end
        step(4'b0000, 1'b1, SYNC + DB - 1);
        n_cmp++; if (busy !== 1'b1) begin n_err++; $display("FAIL clean_busy_before_drop: got %b, required 1", busy); end
        step(4'b0000, 1'b1, 1);
        n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL clean_busy_drop: got %b, required 0", busy); end
        n_cmp++; if (colour_val !== 2'd2) begin n_err++; $display("FAIL clean_val_after_release: got %0d, required 2", colour_val); end
        step(4'b0000, 1'b1, 4);
        n_cmp++; if (sb.size() != 0) begin n_err++; $display("FAIL clean_pending: got %0d pending, required 0", sb.size()); sb.delete(); end
    endtask

    task automatic test_glitch();
        step(4'b0001, 1'b1, 2);
        step(4'b0000, 1'b1, 10);
        n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL glitch_busy: got %b, required 0", busy); end
        n_cmp++; if (colour_val !== 2'd2) begin n_err++; $display("FAIL glitch_val: got %0d, required 2", colour_val); end
    endtask

    task automatic test_multi();
        expect_multi();
        step(4'b0011, 1'b1, 10);
        n_cmp++; if (busy !== 1'b1) begin n_err++; $display("FAIL multi_busy_held: got %b, required 1", busy); end
        step(4'b0000, 1'b1, 10);
        n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL multi_busy_released: got %b, required 0", busy); end
        expect_press(2'd3);
        step(4'b1000, 1'b1, 10);
        step(4'b0000, 1'b1, 10);
        n_cmp++; if (colour_val !== 2'd3) begin n_err++; $display("FAIL multi_next_val: got %0d, required 3", colour_val); end
        n_cmp++; if (sb.size() != 0) begin n_err++; $display("FAIL multi_pending: got %0d pending, required 0", sb.size()); sb.delete(); end
    endtask

    task automatic test_enable_gating();
        step(4'b0010, 1'b0, 10);
        n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL en_idle_busy: got %b, required 0", busy); end
        step(4'b0000, 1'b0, 5);
        // Reach PRESS_DB, then close the window before acceptance
        step(4'b0001, 1'b1, SYNC + 2);
        n_cmp++; if (busy !== 1'b1) begin n_err++; $display("FAIL en_press_busy: got %b, required 1", busy); end
        step(4'b0001, 1'b0, 5);
        step(4'b0001, 1'b1, 10);
        n_cmp++; if (busy !== 1'b1) begin n_err++; $display("FAIL en_reopen_busy: got %b, required 1", busy); end
        step(4'b0000, 1'b1, 10);
        n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL en_release_busy: got %b, required 0", busy); end
        expect_press(2'd0);
        step(4'b0001, 1'b1, 10);
        step(4'b0000, 1'b1, 10);
        n_cmp++; if (colour_val !== 2'd0) begin n_err++; $display("FAIL en_repress_val: got %0d, required 0", colour_val); end
        n_cmp++; if (sb.size() != 0) begin n_err++; $display("FAIL en_pending: got %0d pending, required 0", sb.size()); sb.delete(); end
    endtask

    task automatic test_bouncy_release();
        expect_press(2'd3);
        step(4'b1000, 1'b1, 10);
        step(4'b0000, 1'b1, 1);
        step(4'b1000, 1'b1, 1);
        step(4'b0000, 1'b1, 2);
        step(4'b1000, 1'b1, 1);
        step(4'b0000, 1'b1, 10);
        n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL bounce_busy: got %b, required 0", busy); end
        n_cmp++; if (colour_val !== 2'd3) begin n_err++; $display("FAIL bounce_val: got %0d, required 3", colour_val); end
        expect_press(2'd1);
        step(4'b0010, 1'b1, 10);
        step(4'b0000, 1'b1, 10);
        n_cmp++; if (colour_val !== 2'd1) begin n_err++; $display("FAIL bounce_next_val: got %0d, required 1", colour_val); end
        n_cmp++; if (sb.size() != 0) begin n_err++; $display("FAIL bounce_pending: got %0d pending, required 0", sb.size()); sb.delete(); end
    endtask

    task automatic test_reset_mid_press();
        step(4'b0100, 1'b1, SYNC + 2);
        n_cmp++; if (busy !== 1'b1) begin n_err++; $display("FAIL midrst_busy_before: got %b, required 1", busy); end
        rst = 1'b1;
        btn = 4'b0000;
        @(negedge clk);
        n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL midrst_busy: got %b, required 0", busy); end
        n_cmp++; if (colour_val !== 2'd0) begin n_err++; $display("FAIL midrst_val: got %0d, required 0", colour_val); end
        n_cmp++; if (colour_valid !== 1'b0) begin n_err++; $display("FAIL midrst_valid: got %b, required 0", colour_valid); end
        rst = 1'b0;
        step(4'b0000, 1'b1, 10);
        n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL midrst_busy_after: got %b, required 0", busy); end
        n_cmp++; if (sb.size() != 0) begin n_err++; $display("FAIL midrst_pending: got %0d pending, required 0", sb.size()); sb.delete(); end
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_clean_press();
        test_glitch();
        test_multi();
        test_enable_gating();
        test_bouncy_release();
        test_reset_mid_press();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/button_capture.md
Name: button_capture

Overview:
- Player-input receiver for the Simon Says game. It is the counterpart of the colour encoder and display path that present colours to the player.
- Takes the four raw colour buttons (ui_in[3:0]), then synchronises, debounces and validates them.
- Emits exactly one 2-bit colour code per physical press as a single-cycle strobe. The wait state consumes this in place of its current level-sensitive "any button" input.

Parameters:
- DEBOUNCE_CYCLES, 4, consecutive stable samples required to accept a press or a release; legal range 1..(2^CNT_W - 1).
- CNT_W, 4, width of the debounce counter.

Ports:
- clk  input  1  system clock
- rst  input  1  synchronous, active-high reset
- en  input  1  capture enable; high while the game is in the WAIT state
- btn  input  4  raw buttons; bit i = colour i
- colour_valid  output  1  one-cycle strobe: accepted press
- colour_val  output  2  code of the last accepted press; held until the next strobe
- multi_err  output  1  one-cycle strobe: more than one button seen at press start
- busy  output  1  high whenever the FSM is not in IDLE

Behaviour:
- Reset (synchronous, rst=1 at a clock edge):
  - Synchroniser flops, counter, latched one-hot, colour_valid, colour_val and multi_err all clear to 0.
  - FSM goes to IDLE, so busy=0.
  - rst mid-press aborts the press with no strobe.
  - rst has priority over every other input.
- Synchroniser: 2-flop on btn, giving bs. All FSM decisions use bs only.
- Encoding: 0001->0, 0010->1, 0100->2, 1000->3.
- FSM states: IDLE, PRESS_DB, HELD, RELEASE_DB.
- IDLE:
  - en=1 and bs is one-hot: latch the one-hot, set cnt=1, go to PRESS_DB. If DEBOUNCE_CYCLES=1, accept immediately instead (see accept, below).
  - en=1 and bs has two or more bits set: pulse multi_err, go to RELEASE_DB with cnt=0.
  - en=0 or bs=0: stay in IDLE.
- PRESS_DB:
  - bs equals the latched one-hot: cnt++.
  - When cnt reaches DEBOUNCE_CYCLES, accept: register colour_valid=1 and colour_val=code for one cycle, then go to HELD.
  - bs differs from the latched one-hot (released, bounced or a second button added): go to IDLE with no strobe.
- HELD:
  - Extra buttons are ignored.
  - bs=0: set cnt=1, go to RELEASE_DB.
- RELEASE_DB:
  - bs=0: cnt++. At DEBOUNCE_CYCLES go to IDLE.
  - bs!=0: cnt=0, stay in RELEASE_DB. The state waits for a full clean release regardless of where it was entered from.
- en deasserted:
  - In PRESS_DB or HELD: go to RELEASE_DB with no strobe.
  - In RELEASE_DB: continue as normal.
  - In IDLE: no press is accepted.
  - Effect: a button already held when en rises must be released and pressed again.
- Latency: raw btn stable before edge k gives a colour_valid high for the single cycle following edge k+DEBOUNCE_CYCLES+1.
- Strobe rules:
  - At most one colour_valid per press.
  - colour_valid and multi_err are never high in the same cycle.
  - colour_val changes only on the edge that asserts colour_valid.
- Counter saturates; it never wraps.

Optional Feature:
- BUTTON_SYNC_EN
- Defined: the 2-flop synchroniser is present and latency is as above. This is the setting for the silicon build.
- Undefined: bs = btn directly and latency is 2 cycles shorter (strobe follows edge k+DEBOUNCE_CYCLES-1). FSM behaviour is otherwise identical. This is intended for fast gate-level simulation only.

Test Plan (DEBOUNCE_CYCLES=4, BUTTON_SYNC_EN defined):
- Reset: hold rst=1 for 2 cycles with btn=1111, en=1 -> colour_valid=0, multi_err=0, colour_val=0, busy=0. No strobe for the 3 cycles after release, then normal operation.
- Clean press: en=1, btn=0100 from before edge k, held 30 cycles -> exactly one colour_valid in the cycle after edge k+5 with colour_val=2. colour_val stays 2 after btn=0. busy drops 4+2 cycles after release.
- Glitch: btn=0001 for 2 cycles, then 0 -> no colour_valid and no multi_err. FSM returns to IDLE.
- Multi-press: btn=0011 held 10 cycles then 0 -> one multi_err pulse, no colour_valid. The next clean press of 1000 yields colour_val=3.
- Bouncy release: press 1000 stable for 10 cycles, then release as 0,1000,0,0,1000, then 0 for 10 cycles -> exactly one colour_valid (val=3). A following press of 0010 yields val=1.
- Enable gating: en=0 while btn=0001 is held, then en=1 with it still held -> no strobe. Release for 10 cycles and press again -> one strobe with val=0. In a separate run, rst during PRESS_DB -> no strobe.
